// File: rtl/tick_gated_logic_unit.sv
// tick_gated_logic_unit
//   Programmable-period clock-enable tick generator. On each tick, samples two
//   operand buses and applies a bitwise operation or a wrapping accumulate.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | counter held at 0, no ticks; leaves on en=1
// RUN   | counts 0..R-1, pulses po_tick on wrap, reloads the ratio
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   en         run request (1 = RUN, 0 = IDLE)
//   div_ratio  tick period in clk cycles, 0 treated as 1
//   op_mode    00 AND, 01 OR, 10 XOR, 11 accumulate po_c + (pi_a & pi_b)
//   clr        synchronous clear of po_c, wins over a simultaneous sample
//   pi_a/pi_b  operands
//   po_tick    one-cycle registered clock-enable pulse
//   po_c       registered result
//   po_valid   high the cycle po_c holds a newly sampled value
//   po_busy    high while in RUN
module tick_gated_logic_unit #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic [1:0]       op_mode,
    input  logic             clr,
    input  logic [WIDTH-1:0] pi_a,
    input  logic [WIDTH-1:0] pi_b,
    output logic             po_tick,
    output logic [WIDTH-1:0] po_c,
    output logic             po_valid,
    output logic             po_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] active_ratio;
    logic [DIV_W-1:0] ratio_nxt;
    logic [DIV_W-1:0] r_last;
    logic             tick_nxt;
    logic [WIDTH-1:0] result;

    // The ratio in use is latched at entry and at each wrap, so a mid-period
    // change to div_ratio only shapes the following period.
    assign r_last = ((active_ratio == '0) ? ONE : active_ratio) - ONE;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ratio_nxt = active_ratio;
        tick_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    state_nxt = RUN;
                    ratio_nxt = div_ratio;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == r_last) begin
                    cnt_nxt   = '0;
                    tick_nxt  = 1'b1;
                    ratio_nxt = div_ratio;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        result = '0;
        case (op_mode)
            2'b00:   result = pi_a & pi_b;
            2'b01:   result = pi_a | pi_b;
            2'b10:   result = pi_a ^ pi_b;
            default: result = po_c + (pi_a & pi_b);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            active_ratio <= '0;
            po_tick      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            active_ratio <= ratio_nxt;
            po_tick      <= tick_nxt;
        end
    end

    // A registered tick is consumed regardless of en at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            po_c     <= '0;
            po_valid <= 1'b0;
        end else if (clr) begin
            po_c     <= '0;
            po_valid <= 1'b0;
        end else if (po_tick) begin
            po_c     <= result;
            po_valid <= 1'b1;
        end else begin
            po_valid <= 1'b0;
        end
    end

    assign po_busy = (state == RUN);

endmodule

// File: tb/tb_tick_gated_logic_unit.sv
module tb_tick_gated_logic_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div_ratio;
    logic [1:0]  op_mode;
    logic        clr;
    logic [7:0]  pi_a;
    logic [7:0]  pi_b;
    logic        po_tick;
    logic [7:0]  po_c;
    logic        po_valid;
    logic        po_busy;

    int vec = 0;
    int err = 0;

    tick_gated_logic_unit #(.WIDTH(8), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .div_ratio(div_ratio),
        .op_mode(op_mode), .clr(clr), .pi_a(pi_a), .pi_b(pi_b),
        .po_tick(po_tick), .po_c(po_c), .po_valid(po_valid), .po_busy(po_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        en = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; div_ratio = 16'd4; op_mode = 2'b00;
        clr = 1'b0; pi_a = 8'h00; pi_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if ({po_tick, po_valid, po_busy, po_c} !== 11'b0) begin
            err++;
            $display("FAIL reset_outputs: got tick=%b valid=%b busy=%b c=%h, want all 0",
                     po_tick, po_valid, po_busy, po_c);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    // R=4: ticks at k=4,8,12 after entry edge; valid one cycle later.
    task automatic test_bitwise(input logic [1:0] mode, input logic [7:0] exp_c);
        logic exp_tick, exp_valid;
        go_idle();
        div_ratio = 16'd4; op_mode = mode; pi_a = 8'hF0; pi_b = 8'h3C;
        en = 1'b1;
        step();
        vec++;
        if (po_busy !== 1'b1) begin
            err++;
            $display("FAIL bitwise_busy mode=%0d: got %b want 1", mode, po_busy);
        end
        for (int k = 1; k <= 13; k++) begin
            step();
            exp_tick  = (k % 4 == 0);
            exp_valid = (k % 4 == 1) && (k > 1);
            vec++;
            if (po_tick !== exp_tick || po_valid !== exp_valid) begin
                err++;
                $display("FAIL bitwise_timing mode=%0d k=%0d: got tick=%b valid=%b want tick=%b valid=%b",
                         mode, k, po_tick, po_valid, exp_tick, exp_valid);
            end
            if (exp_valid) begin
                vec++;
                if (po_c !== exp_c) begin
                    err++;
                    $display("FAIL bitwise_result mode=%0d k=%0d: got %h want %h", mode, k, po_c, exp_c);
                end
            end
        end
    endtask

    task automatic test_ratio_change();
        logic exp_tick;
        go_idle();
        div_ratio = 16'd4; op_mode = 2'b00; en = 1'b1;
        step();
        for (int k = 1; k <= 22; k++) begin
            step();
            exp_tick = (k == 4) || (k == 8) || (k == 10) || (k == 12) ||
                       (k == 14) || (k >= 16);
            vec++;
            if (po_tick !== exp_tick) begin
                err++;
                $display("FAIL ratio_change k=%0d: got tick=%b want %b", k, po_tick, exp_tick);
            end
            if (k == 6)  div_ratio = 16'd2;
            if (k == 14) div_ratio = 16'd0;
        end
    endtask

    task automatic test_accum_wrap();
        logic [7:0] exp_c [3];
        exp_c[0] = 8'h80; exp_c[1] = 8'h00; exp_c[2] = 8'h80;
        go_idle();
        div_ratio = 16'd2; op_mode = 2'b11; pi_a = 8'h80; pi_b = 8'h80;
        clr = 1'b1;
        step();
        clr = 1'b0;
        vec++;
        if (po_c !== 8'h00 || po_valid !== 1'b0) begin
            err++;
            $display("FAIL accum_clr: got c=%h valid=%b want 00/0", po_c, po_valid);
        end
        en = 1'b1;
        step();
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 3 || k == 5 || k == 7) begin
                vec++;
                if (po_valid !== 1'b1 || po_c !== exp_c[(k - 3) / 2]) begin
                    err++;
                    $display("FAIL accum_wrap k=%0d: got c=%h valid=%b want %h/1",
                             k, po_c, po_valid, exp_c[(k - 3) / 2]);
                end
            end
            if (k == 8) begin
                vec++;
                if (po_tick !== 1'b1) begin
                    err++;
                    $display("FAIL accum_tick k=8: got %b want 1", po_tick);
                end
                clr = 1'b1;
            end
            if (k == 9) begin
                clr = 1'b0;
                vec++;
                if (po_c !== 8'h00 || po_valid !== 1'b0) begin
                    err++;
                    $display("FAIL accum_clr_on_tick: got c=%h valid=%b want 00/0", po_c, po_valid);
                end
            end
            if (k == 11) begin
                vec++;
                if (po_c !== 8'h80 || po_valid !== 1'b1) begin
                    err++;
                    $display("FAIL accum_after_clr: got c=%h valid=%b want 80/1", po_c, po_valid);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        logic exp_tick;
        go_idle();
        div_ratio = 16'd3; op_mode = 2'b01; pi_a = 8'hF0; pi_b = 8'h3C; en = 1'b1;
        step();
        repeat (3) step();
        vec++;
        if (po_tick !== 1'b1) begin
            err++;
            $display("FAIL en_drop_tick: got %b want 1", po_tick);
        end
        en = 1'b0;
        step();
        vec++;
        if (po_valid !== 1'b1 || po_c !== 8'hFC || po_busy !== 1'b0 || po_tick !== 1'b0) begin
            err++;
            $display("FAIL en_drop_sample: got valid=%b c=%h busy=%b tick=%b want 1/fc/0/0",
                     po_valid, po_c, po_busy, po_tick);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            vec++;
            if (po_tick !== 1'b0 || po_busy !== 1'b0 || po_valid !== 1'b0) begin
                err++;
                $display("FAIL en_drop_idle k=%0d: got tick=%b busy=%b valid=%b want 0/0/0",
                         k, po_tick, po_busy, po_valid);
            end
        end
        en = 1'b1;
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_tick = (k == 3);
            vec++;
            if (po_tick !== exp_tick || po_busy !== 1'b1) begin
                err++;
                $display("FAIL en_reassert k=%0d: got tick=%b busy=%b want %b/1",
                         k, po_tick, po_busy, exp_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic exp_tick;
        go_idle();
        div_ratio = 16'd4; op_mode = 2'b00; pi_a = 8'h55; pi_b = 8'hFF; en = 1'b1;
        step();
        repeat (6) step();
        vec++;
        if (po_c !== 8'h55 || po_busy !== 1'b1) begin
            err++;
            $display("FAIL reset_mid_pre: got c=%h busy=%b want 55/1", po_c, po_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        vec++;
        if ({po_tick, po_valid, po_busy, po_c} !== 11'b0) begin
            err++;
            $display("FAIL reset_mid_async: got tick=%b valid=%b busy=%b c=%h want all 0",
                     po_tick, po_valid, po_busy, po_c);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_tick = (k == 4);
            vec++;
            if (po_tick !== exp_tick) begin
                err++;
                $display("FAIL reset_mid_restart k=%0d: got tick=%b want %b", k, po_tick, exp_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bitwise(2'b00, 8'h30);
        test_bitwise(2'b01, 8'hFC);
        test_bitwise(2'b10, 8'hCC);
        test_ratio_change();
        test_accum_wrap();
        test_en_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
